hex_rate_counter: RTL

HEX_RATE_COUNTER -- requirements
Module: hex_rate_counter

---
 rtl/hex_rate_counter_pkg.sv | 44 ++++
 rtl/hex_to_seg7.sv | 11 +
 rtl/hex_rate_counter.sv | 81 ++++++++
 3 files changed

// File: rtl/hex_rate_counter_pkg.sv
// Shared definitions for the hex rate counter: rate encodings, glyph table, period multipliers.
package hex_rate_counter_pkg;

  typedef enum logic [1:0] {
    RATE_CLK  = 2'b00,
    RATE_1HZ  = 2'b01,
    RATE_2S   = 2'b10,
    RATE_4S   = 2'b11
  } rate_e;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  // Active-low glyphs, bit order g..a, entry n is hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Multiplier of CLK_HZ per rate; RATE_CLK is special-cased to a period of one cycle.
  function automatic int unsigned rate_mult(input rate_e r);
    case (r)
      RATE_CLK: rate_mult = 1;
      RATE_1HZ: rate_mult = 1;
      RATE_2S:  rate_mult = 2;
      default:  rate_mult = 4;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// One hex digit to active-low seven-segment pattern (g..a), purely combinational.
module hex_to_seg7
  import hex_rate_counter_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = SEG_GLYPH[nibble];

endmodule

// File: rtl/hex_rate_counter.sv
// Up/down hex counter advanced by a selectable-rate tick divider, with seven-segment outputs.
module hex_rate_counter
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  Resetn,
  input  logic [1:0]            rate_sel,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned DIV_W = $clog2(4 * CLK_HZ);

  rate_e             rate_q;
  rate_e             rate_in_c;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  reload_c;
  logic              rate_chg_c;
  logic              expire_c;
  logic              wrap_c;
  logic [VAL_W-1:0]  next_val_c;

  // Reload value always follows the incoming rate so a change takes effect on its first edge.
  always_comb begin
    rate_in_c  = rate_e'(rate_sel);
    reload_c   = '0;
    if (rate_in_c != RATE_CLK) begin
      reload_c = DIV_W'(rate_mult(rate_in_c) * CLK_HZ - 1);
    end
    rate_chg_c = (rate_in_c != rate_q);
    expire_c   = en && !load && !rate_chg_c && (div_q == '0);
    next_val_c = up ? (value + VAL_W'(1)) : (value - VAL_W'(1));
    wrap_c     = up ? (&value) : (value == '0);
  end

  // Divider, counter and registered pulses; load outranks a rate change, which outranks en.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      rate_q <= RATE_CLK;
      div_q  <= '0;
      value  <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      rate_q <= rate_in_c;
      tick   <= expire_c;
      wrap   <= expire_c && wrap_c;
      if (load) begin
        value <= load_val;
        div_q <= reload_c;
      end else if (rate_chg_c) begin
        div_q <= reload_c;
      end else if (en) begin
        if (div_q == '0) begin
          div_q <= reload_c;
          value <= next_val_c;
        end else begin
          div_q <= div_q - DIV_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    hex_to_seg7 u_seg (
      .nibble (value[4*i +: 4]),
      .seg_c  (HEX[7*i +: 7])
    );
  end

endmodule
